// File: rtl/segment_scan_if.sv
// Load handshake for segment_scan: one value of DIGITS BCD nibbles offered
// with valid/ready.
//   load_valid  master -> slave  value offered
//   load_ready  slave  -> master controller can take a value
//   load_data   master -> slave  nibble k at [4k+3:4k], digit 0 rightmost
interface segment_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/segment_scan.sv
// Time-multiplexed scan controller for a DIGITS-wide 7-segment display.
// Each digit slot lasts PRESCALE cycles; the first BLANK cycles keep all
// enables low to suppress ghosting. New values arrive over a valid/ready
// handshake into a pending register and are applied only at frame
// boundaries, so a frame never tears.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   ld          segment_scan_if.slave load handshake
//   bcd         nibble for the shared segment decoder (registered)
//   digit_en    one-hot digit enable, active-high (registered)
//   scan_tick   pulse on the last cycle of each slot
//   frame_done  pulse on the last cycle of slot DIGITS-1
//
// Build option: define SEGMENT_SCAN_LZB_EN for leading-zero blanking.
// Digit k>0 stays dark when nibbles k..DIGITS-1 are all zero; digit 0 is
// always driven. Slot timing is unaffected.
//
// state   | meaning
// S_BLANK | dead time at the start of a slot, digit_en = 0
// S_DRIVE | current digit enabled
module segment_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  segment_scan_if.slave       ld,
  output logic [3:0]          bcd,
  output logic [DIGITS-1:0]   digit_en,
  output logic                scan_tick,
  output logic                frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam int W  = 4 * DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  // cnt/idx name the slot position of the cycle the next edge will present,
  // so every output is a plain register of the values below.
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [W-1:0]       disp;
  logic [W-1:0]       pend;
  logic               pend_full;

  logic               apply;
  logic               xfer;
  logic [W-1:0]       disp_nxt;
  logic [DIGITS-1:0]  show;
  logic [DIGITS-1:0]  en_sel;
`ifdef SEGMENT_SCAN_LZB_EN
  logic               acc;
`endif

  // frame_done is high during the last cycle of the frame, so the edge that
  // ends it is the frame boundary. bcd reads through disp_nxt so the new
  // value appears in the very first cycle of the next frame.
  assign apply    = frame_done && pend_full;
  assign xfer     = ld.load_valid && ld.load_ready;
  assign disp_nxt = apply ? pend : disp;

  always_comb begin
    show = '1;
`ifdef SEGMENT_SCAN_LZB_EN
    acc = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc     = acc | (|disp_nxt[4*k +: 4]);
      show[k] = acc || (k == 0);
    end
`endif
  end

  assign en_sel = show[idx] ? (DIGITS'(1) << idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_BLANK;
      cnt           <= '0;
      idx           <= '0;
      disp          <= '0;
      pend          <= '0;
      pend_full     <= 1'b0;
      ld.load_ready <= 1'b1;
      bcd           <= '0;
      digit_en      <= '0;
      scan_tick     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        S_BLANK: begin
          if (cnt >= CNT_BLANK) begin
            state    <= S_DRIVE;
            digit_en <= en_sel;
          end else begin
            digit_en <= '0;
          end
        end
        S_DRIVE: begin
          if (cnt == '0 && BLANK != 0) begin
            state    <= S_BLANK;
            digit_en <= '0;
          end else begin
            digit_en <= en_sel;
          end
        end
        default: begin
          state    <= S_BLANK;
          digit_en <= '0;
        end
      endcase

      bcd        <= disp_nxt[{idx, 2'b00} +: 4];
      scan_tick  <= (cnt == CNT_LAST);
      frame_done <= (cnt == CNT_LAST) && (idx == IDX_LAST);

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // apply and xfer are exclusive: load_ready is low whenever pend_full.
      if (apply) begin
        disp          <= pend;
        pend_full     <= 1'b0;
        ld.load_ready <= 1'b1;
      end
      if (xfer) begin
        pend          <= ld.load_data;
        pend_full     <= 1'b1;
        ld.load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: doc/segment_scan.md
Name: segment_scan

Overview:
- Time-multiplexed scan controller for a DIGITS-wide common-cathode/anode 7-segment display.
- Drives one shared `segment` BCD-to-7-segment decoder (bcd in, a..g out) and steps a one-hot digit enable across the digits.
- Inserts a blanking interval at the start of every digit slot to suppress ghosting.
- Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never tears.

Parameters:
- DIGITS, 4, number of display digits (≥2).
- PRESCALE, 1000, clock cycles per digit slot (≥2).
- BLANK, 16, dead cycles at the start of each slot, with 0 ≤ BLANK < PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- load_valid  in  1  new display value offered.
- load_ready  out  1  controller can accept a value.
- load_data  in  4*DIGITS  BCD nibbles; digit 0 = [3:0] (rightmost), digit k = [4k+3:4k].
- bcd  out  4  nibble to shared segment decoder.
- digit_en  out  DIGITS  one-hot digit enable, active-high.
- scan_tick  out  1  one-cycle pulse on the last cycle of every slot.
- frame_done  out  1  one-cycle pulse on the last cycle of slot DIGITS-1.

Behaviour:
- Single clock domain. Reset is synchronous and active-low; all state is updated only on the rising edge of clk.
- Internal state:
  - slot counter cnt, 0..PRESCALE-1.
  - digit index idx, 0..DIGITS-1.
  - display register disp and pending register pend, each 4*DIGITS wide.
  - pend_full flag.
- Reset values:
  - cnt=0, idx=0, disp=0, pend=0, pend_full=0.
  - load_ready=1, bcd=0, digit_en=0, scan_tick=0, frame_done=0.
- Timing reference: cycle 0 is the first clock edge with rst_n high. Cycle t lies in slot floor(t/PRESCALE), at slot position t mod PRESCALE.
- Slot phases (two-state FSM per slot):
  - BLANK, positions 0..BLANK-1: digit_en=0.
  - DRIVE, positions BLANK..PRESCALE-1: digit_en = 1<<idx.
  - BLANK=0 means the slot is all DRIVE.
- bcd = disp nibble idx for the entire slot, including the BLANK phase, so the decoder settles before enable.
- End of slot (cnt==PRESCALE-1):
  - cnt wraps to 0.
  - idx increments, wrapping from DIGITS-1 to 0.
  - scan_tick=1 in that cycle.
  - frame_done=1 in that cycle if idx==DIGITS-1.
- Outputs must be glitch-free: bcd, digit_en, scan_tick and frame_done are driven from registers with the cycle alignment above.
- Load handshake:
  - Transfer occurs when load_valid && load_ready.
  - On transfer: pend<=load_data, pend_full<=1, load_ready<=0 from the next cycle.
  - load_data may change freely while load_ready=0; it is ignored.
- Frame boundary (frame_done cycle):
  - If pend_full: disp<=pend, pend_full<=0, load_ready<=1 next cycle.
  - The new value is visible on bcd from the first cycle of slot 0 of the next frame.
- Simultaneous events:
  - Transfer in a frame_done cycle while pend_full=0: the value goes to pend, is not applied at that boundary, and is displayed one full frame later.
  - Reset (rst_n low at an edge) overrides all activity: pending load dropped, disp cleared, scan restarts from idx 0, position 0.
- Non-BCD nibbles (A..F) are passed through unchanged; decoding is the decoder's responsibility.

Optional Feature:
- Macro: SEGMENT_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k>0 is blanked (digit_en bit k stays 0 for its whole slot) if disp nibbles k..DIGITS-1 are all 0.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
  - Slot timing, scan_tick and frame_done are unchanged.
- Undefined: all digits are driven every frame regardless of value.

Test Plan (DIGITS=4, PRESCALE=8, BLANK=2, macro undefined unless stated):
- Reset release, no load:
  - digit_en=0 at cycles 0-1, 4'b0001 at 2-7, 0 at 8-9, 4'b0010 at 10-15, 4'b1000 at 26-31.
  - scan_tick at 7, 15, 23, 31; frame_done at 31; bcd=0 throughout.
- load_valid with 16'h1234 at cycle 3:
  - Accepted; load_ready=0 at cycles 4-31 and 1 at cycle 32.
  - bcd=0 through cycle 31, then bcd=4 at 32-39, 3 at 40-47, 2 at 48-55, 1 at 56-63.
- Back-pressure: 16'h1234 accepted at cycle 3, then 16'hABCD held on load_valid from cycle 5:
  - Not accepted until cycle 32.
  - 1234 displayed in frame 32-63; D,C,B,A displayed from cycle 64.
- Load exactly at cycle 31 (frame_done, load_ready=1) with 16'h5678:
  - bcd stays 0 for frame 32-63.
  - bcd=8 from cycle 64.
- Reset mid-frame: after 16'h1234 is displayed, rst_n=0 for one edge at cycle 45:
  - Next cycle: all outputs at reset values, disp=0.
  - Sequence then repeats the first scenario timing.
- SEGMENT_SCAN_LZB_EN defined:
  - 16'h0050: slots 2 and 3 have digit_en=0; slots 0 and 1 are driven.
  - 16'h0000: only digit 0 is driven.
  - With the macro undefined, all four digits are driven for both values.
